// File: rtl/cacheline_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_fill_pkg
// Description : Shared command codes, line geometry and FSM encoding for the
//               cache line fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
package cacheline_fill_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 16;
    localparam int TAG_W      = 23;
    localparam int MADDR_W    = 25;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RDREQ = 2'd1,
        S_FILL  = 2'd2,
        S_WRREQ = 2'd3
    } state_t;

    // Word slot written by a burst beat; the 2-bit sum wraps mod LINE_WORDS.
    function automatic logic [1:0] beat_index(input logic [1:0] start,
                                              input logic [1:0] count);
        return start + count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cacheline_reg.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_reg
// Description : Single cache line storage: four 16-bit words, per-word valid
//               bits and the line tag. Priority: invalidate > fill > update.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_reg
    import cacheline_fill_pkg::*;
#(
    parameter logic [TAG_W-1:0] LINE_RESET_TAG = 23'h7FFFFF
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         invalidate,
    input  logic [TAG_W-1:0]             inv_tag,
    input  logic                         fill,
    input  logic [1:0]                   fill_idx,
    input  logic [WORD_W-1:0]            fill_data,
    input  logic                         update,
    input  logic [TAG_W-1:0]             upd_tag,
    input  logic [1:0]                   upd_idx,
    input  logic [WORD_W-1:0]            upd_data,
    output logic [TAG_W-1:0]             cache_addr,
    output logic [LINE_WORDS*WORD_W-1:0] cache_data_1d,
    output logic [LINE_WORDS-1:0]        cache_valid
);

    logic [WORD_W-1:0]     r_words [LINE_WORDS];
    logic [LINE_WORDS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag;
    logic                  w_hit;

    assign w_hit = (upd_tag == r_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag   <= LINE_RESET_TAG;
            r_valid <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= '0;
            end
        end else if (invalidate) begin
            // Data is left in place; only the valid bits gate its use.
            r_tag   <= inv_tag;
            r_valid <= '0;
        end else if (fill) begin
            r_words[fill_idx] <= fill_data;
            r_valid[fill_idx] <= 1'b1;
        end else if (update && w_hit) begin
            r_words[upd_idx] <= upd_data;
        end
    end

    generate
        for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
            assign cache_data_1d[g*WORD_W +: WORD_W] = r_words[g];
        end
    endgenerate

    assign cache_addr  = r_tag;
    assign cache_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/cacheline_fill.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_fill
// Description : Converts bus READ commands into 4-beat wrapped memory bursts
//               that fill the cache line, and WRITE commands into single-word
//               write-through memory writes.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_fill
    import cacheline_fill_pkg::*;
#(
    parameter int               CRIT_FIRST     = 1,
    parameter logic [TAG_W-1:0] LINE_RESET_TAG = 23'h7FFFFF
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [25:0]                  addr,
    input  logic [WORD_W-1:0]            wdata,
    input  logic [1:0]                   cmd_req,
    output logic                         cmd_ack,
    input  logic                         cache_invalid,
    input  logic                         cache_update,
    output logic [TAG_W-1:0]             cache_addr,
    output logic [LINE_WORDS*WORD_W-1:0] cache_data_1d,
    output logic [LINE_WORDS-1:0]        cache_valid,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [MADDR_W-1:0]           mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic                         mem_rvalid,
    input  logic [WORD_W-1:0]            mem_rdata
);

    state_t             r_state;
    logic [1:0]         r_count;
    logic [MADDR_W-1:0] w_rd_addr;
    logic               w_fill;
    logic [1:0]         w_fill_idx;
    logic               w_unused;

    // Byte-lane select bit has no meaning on a 16-bit word port.
    assign w_unused = addr[0];

    generate
        if (CRIT_FIRST != 0) begin : g_crit_first
            assign w_rd_addr = addr[25:1];
        end else begin : g_line_start
            assign w_rd_addr = {addr[25:3], 2'b00};
        end
    endgenerate

    // Burst start word sits in mem_addr[1:0], which is stable for the burst.
    assign w_fill     = (r_state == S_FILL) && mem_rvalid;
    assign w_fill_idx = beat_index(mem_addr[1:0], r_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 2'd0;
            cmd_ack   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cmd_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_req == CMD_READ) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= w_rd_addr;
                        r_state  <= S_RDREQ;
                    end else if (cmd_req == CMD_WRITE) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr[25:1];
                        mem_wdata <= wdata;
                        r_state   <= S_WRREQ;
                    end
                end
                S_RDREQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        cmd_ack <= 1'b1;
                        r_count <= 2'd0;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_rvalid) begin
                        r_count <= r_count + 2'd1;
                        if (r_count == 2'(LINE_WORDS - 1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WRREQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        cmd_ack <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    cacheline_reg #(
        .LINE_RESET_TAG (LINE_RESET_TAG)
    ) u_line (
        .clk           (clk),
        .reset         (reset),
        .invalidate    (cache_invalid),
        .inv_tag       (addr[25:3]),
        .fill          (w_fill),
        .fill_idx      (w_fill_idx),
        .fill_data     (mem_rdata),
        .update        (cache_update),
        .upd_tag       (addr[25:3]),
        .upd_idx       (addr[2:1]),
        .upd_data      (wdata),
        .cache_addr    (cache_addr),
        .cache_data_1d (cache_data_1d),
        .cache_valid   (cache_valid)
    );

endmodule
`default_nettype wire
